mul_sequencer: RTL and testbench

Multi-cycle shift-add multiply controller that drives the register bank's multiply write path (`mulflag`/`mulout`, which write hi into r19 and lo into r20). It accepts one multiply at a time from decode, iterates 32 cycles, and stalls the pipeline while busy. It also arbitrates the bank's hi/lo write against an ALU writeback that targets r19 or r20 in the same cycle.

---
 rtl/mul_sequencer_if.sv | 27 ++
 rtl/mul_sequencer.sv | 122 ++++++++++++
 tb/tb_mul_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Decode/bank-side signal bundle for the shift-add multiply sequencer.
// master = decode + ALU writeback side, slave = the sequencer itself.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_op;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 alu_regwrite;
  logic [4:0]           alu_wraddr;
  logic                 busy;
  logic                 stall;
  logic                 mulflag;
  logic                 done;
  logic [2*WIDTH-1:0]   mulout;

  modport master (
    output start, signed_op, op_a, op_b, alu_regwrite, alu_wraddr,
    input  busy, stall, mulflag, done, mulout
  );

  modport slave (
    input  start, signed_op, op_a, op_b, alu_regwrite, alu_wraddr,
    output busy, stall, mulflag, done, mulout
  );
endinterface

// File: rtl/mul_sequencer.sv
// 32-iteration shift-add multiplier driving the register bank hi/lo (r19/r20) write path.
// Define MUL_SIGNED_EN to add two's-complement operands and the SIGN correction state.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  mul_sequencer_if.slave    bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [4:0] HI_ADDR = 5'd19;
  localparam logic [4:0] LO_ADDR = 5'd20;

`ifdef MUL_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, SIGN, WB} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
`endif

  state_t           state;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             conflict;

`ifdef MUL_SIGNED_EN
  logic neg;

  // 0x80000000 maps to itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction
`else
  logic unused_signed_op;
  assign unused_signed_op = bus.signed_op;
`endif

  assign addend   = mplier[0] ? mcand : '0;
  assign sum      = {1'b0, acc[PW-1:WIDTH]} + {1'b0, addend};

  // An ALU write to hi or lo holds the multiply back, so the multiply lands last.
  assign conflict = bus.alu_regwrite &&
                    ((bus.alu_wraddr == HI_ADDR) || (bus.alu_wraddr == LO_ADDR));

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain acc/mplier/count updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
`ifdef MUL_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
`ifdef MUL_SIGNED_EN
            if (bus.signed_op) begin
              mcand  <= magnitude(bus.op_a);
              mplier <= magnitude(bus.op_b);
              neg    <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            end else begin
              mcand  <= bus.op_a;
              mplier <= bus.op_b;
              neg    <= 1'b0;
            end
`else
            mcand  <= bus.op_a;
            mplier <= bus.op_b;
`endif
            acc   <= '0;
            count <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == LAST_ITER) begin
`ifdef MUL_SIGNED_EN
            state <= SIGN;
`else
            state <= WB;
`endif
          end
        end

`ifdef MUL_SIGNED_EN
        SIGN: begin
          if (neg) acc <= ~acc + PW'(1);
          state <= WB;
        end
`endif

        WB: begin
          if (!conflict) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.stall   = bus.busy;
  assign bus.mulflag = (state == WB) && !conflict;
  assign bus.done    = bus.mulflag;
  assign bus.mulout  = acc;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomised scoreboard bench for mul_sequencer; expected products and the cycle
// of each hi/lo write strobe come from a plain-arithmetic reference model.
module tb_mul_sequencer;

  localparam int W = 32;
`ifdef MUL_SIGNED_EN
  localparam int LAT = 34;
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam int LAT = 33;
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa;
    longint sbv;
    if (SIGNED_BUILD && sgn) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      return 64'(sa * sbv);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Monitor: pops an expectation whenever the bank write strobe appears.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      check("done_vs_mulflag", 64'(bus.done), 64'(bus.mulflag));
      check("stall_vs_busy", 64'(bus.stall), 64'(bus.busy));
      if (bus.mulflag) begin
        if (sb.size() == 0) begin
          check("unexpected_mulflag", 64'(bus.mulflag), 64'd0);
        end else begin
          e = sb.pop_front();
          check("mulout", bus.mulout, e.prod);
          check("mulflag_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        check("mulflag_missing", 64'(bus.mulflag), 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic drive_alu_random();
    bus.alu_regwrite = 1'($urandom_range(0, 1));
    bus.alu_wraddr   = 5'($urandom_range(0, 31));
  endtask

  task automatic drive_alu_clear();
    bus.alu_regwrite = 1'($urandom_range(0, 1));
    bus.alu_wraddr   = 5'($urandom_range(0, 31));
    if (bus.alu_wraddr == 5'd19 || bus.alu_wraddr == 5'd20) bus.alu_regwrite = 1'b0;
  endtask

  task automatic drive_alu_conflict();
    bus.alu_regwrite = 1'b1;
    bus.alu_wraddr   = ($urandom_range(0, 1) != 0) ? 5'd19 : 5'd20;
  endtask

  // One multiply from an idle DUT; nconf = ALU hi/lo writes held over the first WB cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                        input logic [63:0] exp, input int nconf, input bit poke_busy);
    exp_t e;
    int   e0;
    int   wb0;
    int   fire;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.signed_op = sgn;
    drive_alu_random();
    e0   = cyc + 1;
    wb0  = e0 + LAT - 1;
    fire = wb0 + nconf;
    e.prod = exp;
    e.due  = fire;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    while (cyc <= fire) begin
      if (cyc >= wb0 && cyc < fire) drive_alu_conflict();
      else if (cyc == fire) drive_alu_clear();
      else drive_alu_random();
      if (poke_busy && cyc == e0 + 5) begin
        bus.start = 1'b1;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.alu_regwrite = 1'b0;
    check("busy_after_write", 64'(bus.busy), 64'd0);
    check("mulout_hold", bus.mulout, exp);
  endtask

  task automatic reset_abort(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.signed_op = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_mulout", bus.mulout, 64'd0);
    check("abort_mulflag", 64'(bus.mulflag), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_still_idle", 64'(bus.busy), 64'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    int          drain;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.alu_regwrite = 1'b0;
    bus.alu_wraddr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_stall", 64'(bus.stall), 64'd0);
    check("reset_mulflag", 64'(bus.mulflag), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_mulout", bus.mulout, 64'd0);
    rst = 1'b0;

    run_op(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 1'b0);
    check("r19_max", 64'(bus.mulout[63:32]), 64'h0000_0000_FFFF_FFFE);
    check("r20_max", 64'(bus.mulout[31:0]), 64'h0000_0000_0000_0001);
`ifdef MUL_SIGNED_EN
    run_op(32'hFFFF_FFFB, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 1'b0);
`else
    run_op(32'hFFFF_FFFB, 32'd3, 1'b1, 64'h0000_0002_FFFF_FFF1, 0, 1'b0);
`endif
    run_op(32'd0, 32'hDEAD_BEEF, 1'b0, 64'd0, 0, 1'b0);
    run_op(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 2, 1'b0);
    reset_abort(32'h1234_5678, 32'h9ABC_DEF0);
    run_op(32'd12345, 32'd6789, 1'b0, ref_mul(32'd12345, 32'd6789, 1'b0), 0, 1'b0);
    run_op(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("no_second_op", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'd0;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s, ref_mul(a, b, s), $urandom_range(0, 3), 1'b0);
    end

    drain = 0;
    while (sb.size() != 0 && drain < 100) begin
      @(posedge clk);
      drain++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
